// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage load/store controller.
// Accepts one load or store per request, rejects misaligned accesses,
// drives a single-port data memory over a req/ack handshake with a wait
// timeout, stalls the pipeline while the access is in flight, and returns
// lane-selected, zero/sign-extended load data.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LH  = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SB  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    // Last counter value before the wait budget is exhausted.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      state_r;
    logic [2:0]  op_r;      // latched operation
    logic [1:0]  lane_r;    // latched byte offset within the word
    logic [7:0]  cnt_r;     // REQ cycles spent without acknowledge

    // Loads occupy op codes 0..4, stores 5..7.
    function automatic logic is_load_f(input logic [2:0] op);
        return (op <= OP_LH);
    endfunction

    // Word ops need addr[1:0]==0, halfword ops need addr[0]==0.
    function automatic logic misaligned_f(input logic [2:0] op, input logic [1:0] a);
        logic bad;
        case (op)
            OP_LW, OP_SW:          bad = (a != 2'b00);
            OP_LH, OP_LHU, OP_SH:  bad = a[0];
            default:               bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte enables for stores; loads never assert byte enables.
    function automatic logic [3:0] store_be_f(input logic [2:0] op, input logic [1:0] a);
        logic [3:0] be;
        case (op)
            OP_SW:   be = 4'b1111;
            OP_SB:   be = 4'b0001 << a;
            OP_SH:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data across lanes so the enabled lanes see the right bytes.
    function automatic logic [31:0] store_data_f(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] d;
        case (op)
            OP_SW:   d = wd;
            OP_SB:   d = {4{wd[7:0]}};
            OP_SH:   d = {2{wd[15:0]}};
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    // Select the addressed byte/half from the read word and extend it.
    function automatic logic [31:0] load_ext_f(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LW:   r = word;
            OP_LBU:  r = {24'h00_0000, b};
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LHU:  r = {16'h0000, h};
            OP_LH:   r = {{16{h[15]}}, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Hold the instruction in M until the access reaches DONE or ERR.
    assign stall = req_valid && (state_r != DONE) && (state_r != ERR);

    // Access FSM with registered memory-side signals, pulses and load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            op_r      <= 3'd0;
            lane_r    <= 2'd0;
            cnt_r     <= 8'd0;
            done      <= 1'b0;
            rdata     <= 32'h0000_0000;
            adel      <= 1'b0;
            ades      <= 1'b0;
            bus_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    done    <= 1'b0;
                    adel    <= 1'b0;
                    ades    <= 1'b0;
                    bus_err <= 1'b0;
                    cnt_r   <= 8'd0;
                    if (req_valid) begin
                        op_r   <= req_op;
                        lane_r <= req_addr[1:0];
                        if (misaligned_f(req_op, req_addr[1:0])) begin
                            // Alignment faults never reach the memory.
                            state_r <= ERR;
                            adel    <= is_load_f(req_op);
                            ades    <= !is_load_f(req_op);
                        end else begin
                            state_r   <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= !is_load_f(req_op);
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= store_be_f(req_op, req_addr[1:0]);
                            mem_wdata <= store_data_f(req_op, req_wdata);
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        // Acknowledge wins over a coincident timeout.
                        state_r   <= DONE;
                        done      <= 1'b1;
                        rdata     <= is_load_f(op_r) ? load_ext_f(op_r, lane_r, mem_rdata)
                                                     : 32'h0000_0000;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0000_0000;
                        mem_be    <= 4'b0000;
                        mem_wdata <= 32'h0000_0000;
                    end else if (cnt_r == WAIT_LAST) begin
                        state_r   <= ERR;
                        bus_err   <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0000_0000;
                        mem_be    <= 4'b0000;
                        mem_wdata <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                ERR: begin
                    adel    <= 1'b0;
                    ades    <= 1'b0;
                    bus_err <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (TIMEOUT=4).
// Cycle convention: inputs are driven 1 time unit after a rising edge and
// outputs are checked 1 unit later; "cycle n" counts rising edges from the
// cycle in which the request is first presented.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .adel      (adel),
        .ades      (ades),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next cycle: drive point is 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
        req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        step(); step();
        reset = 1'b0;
        #1;
        total_cnt++; if ({stall, done, adel, ades, bus_err, mem_req, mem_we} !== 7'b0)
            $display("FAIL reset_flags: got %b expected 0000000", {stall, done, adel, ades, bus_err, mem_req, mem_we});
        else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 00000000", rdata); else pass_cnt++;
        total_cnt++; if ({mem_addr, mem_be, mem_wdata} !== 68'h0)
            $display("FAIL reset_mem_bus: got %h/%b/%h expected 0", mem_addr, mem_be, mem_wdata);
        else pass_cnt++;
        step();
    endtask

    task automatic test_load_byte();
        // lb at 0x1003, ack on the third REQ cycle (cycle 3), done in cycle 4
        req_valid = 1'b1; req_op = 3'd2; req_addr = 32'h0000_1003; mem_rdata = 32'h80FF_7F01;
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL lb_stall_c0: got %b expected 1", stall); else pass_cnt++;
        step(); #1;
        total_cnt++; if (mem_req !== 1'b1) $display("FAIL lb_memreq_c1: got %b expected 1", mem_req); else pass_cnt++;
        total_cnt++; if ({mem_we, mem_be} !== 5'b0) $display("FAIL lb_we_be_c1: got %b expected 00000", {mem_we, mem_be}); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h0000_1000) $display("FAIL lb_addr_c1: got %h expected 00001000", mem_addr); else pass_cnt++;
        step(); #1;
        total_cnt++; if ({mem_req, stall} !== 2'b11) $display("FAIL lb_wait_c2: got %b expected 11", {mem_req, stall}); else pass_cnt++;
        step();
        mem_ack = 1'b1; #1;
        total_cnt++; if ({stall, done} !== 2'b10) $display("FAIL lb_c3: got %b expected 10", {stall, done}); else pass_cnt++;
        step();
        mem_ack = 1'b0; #1;
        total_cnt++; if ({done, stall, mem_req} !== 3'b100) $display("FAIL lb_done_c4: got %b expected 100", {done, stall, mem_req}); else pass_cnt++;
        total_cnt++; if (rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata: got %h expected ffffff80", rdata); else pass_cnt++;
        req_valid = 1'b0;
        step(); #1;
        total_cnt++; if (done !== 1'b0) $display("FAIL lb_done_c5: got %b expected 0", done); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        // lhu at 0x2002 with immediate ack, then lh accepted in the mandatory IDLE cycle
        req_valid = 1'b1; req_op = 3'd3; req_addr = 32'h0000_2002; mem_rdata = 32'hBEEF_1234;
        step();
        mem_ack = 1'b1; #1;
        total_cnt++; if (mem_req !== 1'b1) $display("FAIL lhu_memreq_c1: got %b expected 1", mem_req); else pass_cnt++;
        step();
        mem_ack = 1'b0; #1;
        total_cnt++; if (done !== 1'b1) $display("FAIL lhu_done_c2: got %b expected 1", done); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0000_BEEF) $display("FAIL lhu_rdata: got %h expected 0000beef", rdata); else pass_cnt++;
        step();
        req_op = 3'd4; #1;
        total_cnt++; if ({stall, done} !== 2'b10) $display("FAIL lh_accept_c3: got %b expected 10", {stall, done}); else pass_cnt++;
        step();
        mem_ack = 1'b1; #1;
        total_cnt++; if (mem_req !== 1'b1) $display("FAIL lh_memreq: got %b expected 1", mem_req); else pass_cnt++;
        step();
        mem_ack = 1'b0; #1;
        total_cnt++; if ({done, rdata} !== {1'b1, 32'hFFFF_BEEF}) $display("FAIL lh_rdata: got %b/%h expected 1/ffffbeef", done, rdata); else pass_cnt++;
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_store();
        logic [2:0]  ops  [3] = '{3'd6, 3'd7, 3'd5};
        logic [31:0] adrs [3] = '{32'h10, 32'h12, 32'h14};
        logic [31:0] wds  [3] = '{32'h0000_00AB, 32'h1234_CDEF, 32'h1234_5678};
        logic [3:0]  bes  [3] = '{4'b0001, 4'b1100, 4'b1111};
        logic [31:0] dats [3] = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'h1234_5678};
        logic [31:0] was  [3] = '{32'h10, 32'h10, 32'h14};
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_op = ops[i]; req_addr = adrs[i]; req_wdata = wds[i];
            step();
            mem_ack = 1'b1; req_wdata = 32'hDEAD_DEAD; #1;
            total_cnt++; if ({mem_req, mem_we, mem_be} !== {2'b11, bes[i]})
                $display("FAIL st%0d_req_we_be: got %b expected %b", i, {mem_req, mem_we, mem_be}, {2'b11, bes[i]});
            else pass_cnt++;
            total_cnt++; if ({mem_addr, mem_wdata} !== {was[i], dats[i]})
                $display("FAIL st%0d_addr_data: got %h/%h expected %h/%h", i, mem_addr, mem_wdata, was[i], dats[i]);
            else pass_cnt++;
            step();
            mem_ack = 1'b0; #1;
            total_cnt++; if ({done, mem_req} !== 2'b10) $display("FAIL st%0d_done: got %b expected 10", i, {done, mem_req}); else pass_cnt++;
            req_valid = 1'b0;
            step();
        end
    endtask

    task automatic test_misaligned();
        // lw at 0x1001 -> adel in cycle 1, no mem_req
        req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h0000_1001;
        step(); #1;
        total_cnt++; if ({adel, ades, mem_req, stall} !== 4'b1000)
            $display("FAIL lw_adel_c1: got %b expected 1000", {adel, ades, mem_req, stall});
        else pass_cnt++;
        step();
        req_op = 3'd7; req_addr = 32'h0000_0003; #1;
        total_cnt++; if ({adel, stall} !== 2'b01) $display("FAIL adel_clear_c2: got %b expected 01", {adel, stall}); else pass_cnt++;
        step(); #1;
        total_cnt++; if ({adel, ades, mem_req} !== 3'b010) $display("FAIL sh_ades: got %b expected 010", {adel, ades, mem_req}); else pass_cnt++;
        step();
        req_op = 3'd0; req_addr = 32'h0000_0100; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 1'b1; #1;
        total_cnt++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0100})
            $display("FAIL realign_req: got %b/%h expected 1/00000100", mem_req, mem_addr);
        else pass_cnt++;
        step();
        mem_ack = 1'b0; #1;
        total_cnt++; if ({done, rdata} !== {1'b1, 32'hCAFE_F00D}) $display("FAIL realign_done: got %b/%h expected 1/cafef00d", done, rdata); else pass_cnt++;
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h0000_0040;
        step(); step(); step(); step(); #1;
        total_cnt++; if ({mem_req, bus_err} !== 2'b10) $display("FAIL to_c4: got %b expected 10", {mem_req, bus_err}); else pass_cnt++;
        step(); #1;
        total_cnt++; if ({bus_err, mem_req, stall} !== 3'b100) $display("FAIL to_buserr_c5: got %b expected 100", {bus_err, mem_req, stall}); else pass_cnt++;
        step();
        req_valid = 1'b0; mem_ack = 1'b1; #1;
        total_cnt++; if (bus_err !== 1'b0) $display("FAIL to_pulse_c6: got %b expected 0", bus_err); else pass_cnt++;
        step();
        mem_ack = 1'b0; #1;
        total_cnt++; if ({done, mem_req} !== 2'b00) $display("FAIL to_late_ack: got %b expected 00", {done, mem_req}); else pass_cnt++;
    endtask

    task automatic test_ack_at_timeout();
        // ack on the 4th REQ cycle coincides with the timeout boundary
        req_valid = 1'b1; req_op = 3'd1; req_addr = 32'h0000_0041; mem_rdata = 32'h0000_9A00;
        step(); step(); step(); step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; #1;
        total_cnt++; if ({done, bus_err} !== 2'b10) $display("FAIL ack_vs_to: got %b expected 10", {done, bus_err}); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0000_009A) $display("FAIL ack_vs_to_rdata: got %h expected 0000009a", rdata); else pass_cnt++;
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_midway();
        req_valid = 1'b1; req_op = 3'd6; req_addr = 32'h0000_0081; req_wdata = 32'h55;
        step(); step();
        reset = 1'b1; req_valid = 1'b0;
        step();
        reset = 1'b0; mem_ack = 1'b1; #1;
        total_cnt++; if ({stall, done, mem_req, mem_we, mem_be} !== 8'b0)
            $display("FAIL rst_mid_c3: got %b expected 00000000", {stall, done, mem_req, mem_we, mem_be});
        else pass_cnt++;
        total_cnt++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL rst_mid_bus: got %h/%h expected 0", mem_addr, mem_wdata); else pass_cnt++;
        step();
        mem_ack = 1'b0; #1;
        total_cnt++; if ({done, mem_req} !== 2'b00) $display("FAIL rst_mid_ack: got %b expected 00", {done, mem_req}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_back_to_back();
        test_store();
        test_misaligned();
        test_timeout();
        test_ack_at_timeout();
        test_reset_midway();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
